// File: rtl/eros_pkg.sv
// Shared EROS types and constants: OBI port structs, default AXI4 structs and
// the state encoding of the OBI-to-AXI manager bridge.
package eros_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_RESP,
        ST_DRAIN
    } obi2axi_state_e;

    localparam logic [2:0]  AXI_SIZE_32B          = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR        = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY         = 2'b00;
    localparam logic [1:0]  AXI_RESP_EXOKAY       = 2'b01;
    localparam logic [1:0]  AXI_RESP_SLVERR       = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR       = 2'b11;
    localparam logic [31:0] TIMEOUT_RDATA_DEFAULT = 32'hDEAD_BEEF;

    localparam int unsigned EROS_AXI_ADDR_W = 32;
    localparam int unsigned EROS_AXI_DATA_W = 32;
    localparam int unsigned EROS_AXI_ID_W   = 4;
    localparam int unsigned EROS_AXI_USER_W = 1;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic [EROS_AXI_ID_W-1:0]   id;
        logic [EROS_AXI_ADDR_W-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       lock;
        logic [3:0]                 cache;
        logic [2:0]                 prot;
        logic [3:0]                 qos;
        logic [3:0]                 region;
        logic [5:0]                 atop;
        logic [EROS_AXI_USER_W-1:0] user;
    } eros_axi_aw_t;

    typedef struct packed {
        logic [EROS_AXI_DATA_W-1:0]   data;
        logic [EROS_AXI_DATA_W/8-1:0] strb;
        logic                         last;
        logic [EROS_AXI_USER_W-1:0]   user;
    } eros_axi_w_t;

    typedef struct packed {
        logic [EROS_AXI_ID_W-1:0]   id;
        logic [1:0]                 resp;
        logic [EROS_AXI_USER_W-1:0] user;
    } eros_axi_b_t;

    typedef struct packed {
        logic [EROS_AXI_ID_W-1:0]   id;
        logic [EROS_AXI_ADDR_W-1:0] addr;
        logic [7:0]                 len;
        logic [2:0]                 size;
        logic [1:0]                 burst;
        logic                       lock;
        logic [3:0]                 cache;
        logic [2:0]                 prot;
        logic [3:0]                 qos;
        logic [3:0]                 region;
        logic [EROS_AXI_USER_W-1:0] user;
    } eros_axi_ar_t;

    typedef struct packed {
        logic [EROS_AXI_ID_W-1:0]   id;
        logic [EROS_AXI_DATA_W-1:0] data;
        logic [1:0]                 resp;
        logic                       last;
        logic [EROS_AXI_USER_W-1:0] user;
    } eros_axi_r_t;

    typedef struct packed {
        eros_axi_aw_t aw;
        logic         aw_valid;
        eros_axi_w_t  w;
        logic         w_valid;
        logic         b_ready;
        eros_axi_ar_t ar;
        logic         ar_valid;
        logic         r_ready;
    } eros_axi_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         ar_ready;
        logic         w_ready;
        logic         b_valid;
        eros_axi_b_t  b;
        logic         r_valid;
        eros_axi_r_t  r;
    } eros_axi_rsp_t;

    // SLVERR and DECERR both have the MSB set.
    function automatic logic axi_resp_is_err(logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/eros_obi_to_axi_mst.sv
// EROS external OBI manager port to AXI4 manager bridge: one outstanding
// access, single-beat bursts, with a response timeout and late-response drain.
module eros_obi_to_axi_mst
    import eros_pkg::*;
#(
    parameter int unsigned                  AxiAddrWidth  = 32,
    parameter int unsigned                  AxiDataWidth  = 32,
    parameter int unsigned                  AxiIdWidth    = 4,
    parameter logic [AxiIdWidth-1:0]        AxiId         = '0,
    parameter int unsigned                  TimeoutCycles = 1024,
    parameter logic [31:0]                  TimeoutRdata  = TIMEOUT_RDATA_DEFAULT,
    parameter type                          axi_req_t     = eros_axi_req_t,
    parameter type                          axi_rsp_t     = eros_axi_rsp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  obi_req_i,
    output obi_resp_t obi_resp_o,
    output axi_req_t  axi_req_o,
    input  axi_rsp_t  axi_rsp_i,
    output logic      err_o,
    output logic      busy_o
);

    if (AxiDataWidth != 32) begin : gen_dw_check
        $error("eros_obi_to_axi_mst: AxiDataWidth must be 32");
    end
    if (AxiAddrWidth < 32) begin : gen_aw_check
        $error("eros_obi_to_axi_mst: AxiAddrWidth must be at least 32");
    end

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CNT_LAST = CntW'(TimeoutCycles - 1);

    obi2axi_state_e  state_reg;
    logic            we_reg;
    logic [3:0]      be_reg;
    logic [31:0]     addr_reg;
    logic [31:0]     wdata_reg;
    logic [31:0]     rdata_reg;
    logic            aw_done_reg, w_done_reg, ar_done_reg;
    logic            timed_out_reg;
    logic            err_reg;
    logic [CntW-1:0] cnt_reg;

    logic gnt, pending, cnt_run, timeout_hit;
    logic aw_valid, w_valid, ar_valid, b_ready, r_ready;
    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

    assign gnt = obi_req_i.req && (state_reg == ST_IDLE);

    // After a timeout, request channels already raised stay valid through RESP
    // and DRAIN until accepted, so no AXI valid is ever withdrawn.
    assign pending  = timed_out_reg && (state_reg == ST_RESP || state_reg == ST_DRAIN);
    assign aw_valid = (state_reg == ST_WR_REQ || (pending && we_reg)) && !aw_done_reg;
    assign w_valid  = (state_reg == ST_WR_REQ || (pending && we_reg)) && !w_done_reg;
    assign ar_valid = (state_reg == ST_RD_AR || (pending && !we_reg)) && !ar_done_reg;
    assign b_ready  = (state_reg == ST_WR_B) || (state_reg == ST_DRAIN && we_reg);
    assign r_ready  = (state_reg == ST_RD_R) || (state_reg == ST_DRAIN && !we_reg);

    assign aw_hs = aw_valid && axi_rsp_i.aw_ready;
    assign w_hs  = w_valid  && axi_rsp_i.w_ready;
    assign ar_hs = ar_valid && axi_rsp_i.ar_ready;
    assign b_hs  = b_ready  && axi_rsp_i.b_valid;
    assign r_hs  = r_ready  && axi_rsp_i.r_valid;

    assign cnt_run = (state_reg == ST_WR_REQ) || (state_reg == ST_WR_B) ||
                     (state_reg == ST_RD_AR)  || (state_reg == ST_RD_R);
    assign timeout_hit = (TimeoutCycles != 0) && cnt_run && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            we_reg        <= 1'b0;
            be_reg        <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            ar_done_reg   <= 1'b0;
            timed_out_reg <= 1'b0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            if (aw_hs) aw_done_reg <= 1'b1;
            if (w_hs)  w_done_reg  <= 1'b1;
            if (ar_hs) ar_done_reg <= 1'b1;
            if (cnt_run) cnt_reg <= cnt_reg + CntW'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (gnt) begin
                        we_reg        <= obi_req_i.we;
                        be_reg        <= obi_req_i.be;
                        addr_reg      <= obi_req_i.addr;
                        wdata_reg     <= obi_req_i.wdata;
                        aw_done_reg   <= 1'b0;
                        w_done_reg    <= 1'b0;
                        ar_done_reg   <= 1'b0;
                        timed_out_reg <= 1'b0;
                        cnt_reg       <= '0;
                        state_reg     <= obi_req_i.we ? ST_WR_REQ : ST_RD_AR;
                    end
                end
                ST_WR_REQ: begin
                    if (timeout_hit) begin
                        timed_out_reg <= 1'b1;
                        err_reg       <= 1'b1;
                        rdata_reg     <= TimeoutRdata;
                        state_reg     <= ST_RESP;
                    end else if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                        state_reg <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    // A response landing on the timeout cycle wins over the timeout.
                    if (b_hs) begin
                        err_reg   <= axi_resp_is_err(axi_rsp_i.b.resp);
                        rdata_reg <= '0;
                        state_reg <= ST_RESP;
                    end else if (timeout_hit) begin
                        timed_out_reg <= 1'b1;
                        err_reg       <= 1'b1;
                        rdata_reg     <= TimeoutRdata;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RD_AR: begin
                    if (timeout_hit) begin
                        timed_out_reg <= 1'b1;
                        err_reg       <= 1'b1;
                        rdata_reg     <= TimeoutRdata;
                        state_reg     <= ST_RESP;
                    end else if (ar_hs) begin
                        state_reg <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (r_hs) begin
                        if (axi_rsp_i.r.resp == AXI_RESP_OKAY) begin
                            rdata_reg <= axi_rsp_i.r.data;
                            err_reg   <= 1'b0;
                        end else begin
                            rdata_reg <= TimeoutRdata;
                            err_reg   <= 1'b1;
                        end
                        state_reg <= ST_RESP;
                    end else if (timeout_hit) begin
                        timed_out_reg <= 1'b1;
                        err_reg       <= 1'b1;
                        rdata_reg     <= TimeoutRdata;
                        state_reg     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    err_reg   <= 1'b0;
                    state_reg <= timed_out_reg ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: begin
                    if (we_reg ? b_hs : r_hs) begin
                        timed_out_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw.id    = AxiId;
        axi_req_o.aw.addr  = AxiAddrWidth'(addr_reg);
        axi_req_o.aw.len   = 8'd0;
        axi_req_o.aw.size  = AXI_SIZE_32B;
        axi_req_o.aw.burst = AXI_BURST_INCR;
        axi_req_o.aw_valid = aw_valid;
        axi_req_o.w.data   = wdata_reg;
        axi_req_o.w.strb   = be_reg;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid;
        axi_req_o.b_ready  = b_ready;
        axi_req_o.ar.id    = AxiId;
        axi_req_o.ar.addr  = AxiAddrWidth'(addr_reg);
        axi_req_o.ar.len   = 8'd0;
        axi_req_o.ar.size  = AXI_SIZE_32B;
        axi_req_o.ar.burst = AXI_BURST_INCR;
        axi_req_o.ar_valid = ar_valid;
        axi_req_o.r_ready  = r_ready;
    end

    always_comb begin
        obi_resp_o        = '0;
        obi_resp_o.gnt    = gnt;
        obi_resp_o.rvalid = (state_reg == ST_RESP);
        obi_resp_o.rdata  = rdata_reg;
    end

    assign err_o  = err_reg;
    assign busy_o = (state_reg != ST_IDLE);

    logic unused_rsp_bits;
    assign unused_rsp_bits = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.r.id,
                               axi_rsp_i.r.last, axi_rsp_i.r.user};

endmodule

// File: tb/tb_eros_obi_to_axi_mst.sv
// Directed bench for eros_obi_to_axi_mst: a scripted AXI subordinate, and a
// scoreboard of expected OBI responses pushed at grant and popped at rvalid.
module tb_eros_obi_to_axi_mst;
    import eros_pkg::*;

    localparam int unsigned TO_CYCLES = 16;
    localparam logic [3:0]  TB_ID     = 4'h5;

    logic          clk = 1'b0;
    logic          rst;
    obi_req_t      obi_req;
    obi_resp_t     obi_resp;
    eros_axi_req_t axi_req;
    eros_axi_rsp_t axi_rsp;
    logic          err, busy;

    always #5 clk = ~clk;

    eros_obi_to_axi_mst #(
        .AxiAddrWidth (32),
        .AxiDataWidth (32),
        .AxiIdWidth   (4),
        .AxiId        (TB_ID),
        .TimeoutCycles(TO_CYCLES),
        .TimeoutRdata (32'hDEAD_BEEF),
        .axi_req_t    (eros_axi_req_t),
        .axi_rsp_t    (eros_axi_rsp_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .obi_req_i (obi_req),
        .obi_resp_o(obi_resp),
        .axi_req_o (axi_req),
        .axi_rsp_i (axi_rsp),
        .err_o     (err),
        .busy_o    (busy)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;
    int   aw_hs_cnt = 0, w_hs_cnt = 0, rv_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (axi_req.aw_valid && axi_rsp.aw_ready) aw_hs_cnt++;
            if (axi_req.w_valid && axi_rsp.w_ready)   w_hs_cnt++;
            if (obi_resp.rvalid)                       rv_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an OBI request, expect it granted this cycle, and record its response.
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
        exp_t e;
        obi_req.req   = 1'b1;
        obi_req.we    = we;
        obi_req.be    = be;
        obi_req.addr  = addr;
        obi_req.wdata = wdata;
        @(negedge clk);
        chk("issue_gnt", obi_resp.gnt, 1'b1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        tick();
        obi_req.req = 1'b0;
    endtask

    // Wait a bounded number of cycles for rvalid and compare against the scoreboard.
    task automatic wait_rsp(input int max_cyc, output int cyc);
        exp_t e;
        logic seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (obi_resp.rvalid) begin
                seen = 1'b1;
                cyc  = i + 1;
                break;
            end
        end
        chk("rvalid_seen", seen, 1'b1);
        if (seen) begin
            chk("sb_nonempty", (sb_q.size() > 0) ? 1'b1 : 1'b0, 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d: rdata=%h err=%b latency=%0d", txn, obi_resp.rdata, err, cyc);
                chk("rsp_rdata", obi_resp.rdata, e.rdata);
                chk("rsp_err", err, e.err);
            end
        end
    endtask

    initial begin
        int cyc, rv0, aw0, w0;
        obi_req = '0;
        axi_rsp = '0;
        rst     = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_gnt", obi_resp.gnt, 1'b0);
        chk("rst_rvalid", obi_resp.rvalid, 1'b0);
        chk("rst_rdata", obi_resp.rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                           axi_req.b_ready, axi_req.r_ready}, 5'b0);
        tick();
        rst = 1'b0;

        // Write with zero-latency AW/W acceptance and OKAY response
        rv0 = rv_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        issue(1'b1, 4'b0110, 32'h2000_0010, 32'hA5A5_1234, 32'h0, 1'b0);
        axi_rsp.aw_ready = 1'b1;
        axi_rsp.w_ready  = 1'b1;
        @(negedge clk);
        chk("t1_awvalid", axi_req.aw_valid, 1'b1);
        chk("t1_wvalid", axi_req.w_valid, 1'b1);
        chk("t1_awaddr", axi_req.aw.addr, 32'h2000_0010);
        chk("t1_awid", axi_req.aw.id, TB_ID);
        chk("t1_awlen", axi_req.aw.len, 8'd0);
        chk("t1_awsize", axi_req.aw.size, 3'b010);
        chk("t1_awburst", axi_req.aw.burst, 2'b01);
        chk("t1_aw_misc", {axi_req.aw.cache, axi_req.aw.prot, axi_req.aw.qos,
                           axi_req.aw.region, axi_req.aw.lock, axi_req.aw.atop}, 24'h0);
        chk("t1_wdata", axi_req.w.data, 32'hA5A5_1234);
        chk("t1_wstrb", axi_req.w.strb, 4'b0110);
        chk("t1_wlast", axi_req.w.last, 1'b1);
        chk("t1_bready_req", axi_req.b_ready, 1'b0);
        tick();
        axi_rsp.aw_ready = 1'b0;
        axi_rsp.w_ready  = 1'b0;
        axi_rsp.b_valid  = 1'b1;
        axi_rsp.b.resp   = AXI_RESP_OKAY;
        @(negedge clk);
        chk("t1_aw_dropped", axi_req.aw_valid, 1'b0);
        chk("t1_w_dropped", axi_req.w_valid, 1'b0);
        chk("t1_bready", axi_req.b_ready, 1'b1);
        tick();
        axi_rsp.b_valid = 1'b0;
        wait_rsp(4, cyc);
        chk("t1_rsp_latency", cyc, 1);
        tick();
        @(negedge clk);
        chk("t1_idle", busy, 1'b0);
        chk("t1_rvalid_count", rv_cnt - rv0, 1);
        chk("t1_aw_count", aw_hs_cnt - aw0, 1);
        chk("t1_w_count", w_hs_cnt - w0, 1);
        tick();

        // Write where W is accepted three cycles before AW
        rv0 = rv_cnt; aw0 = aw_hs_cnt; w0 = w_hs_cnt;
        issue(1'b1, 4'hF, 32'h2000_0020, 32'h0BAD_CAFE, 32'h0, 1'b0);
        axi_rsp.w_ready = 1'b1;
        @(negedge clk);
        chk("t2_wdata", axi_req.w.data, 32'h0BAD_CAFE);
        tick();
        axi_rsp.w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) axi_rsp.aw_ready = 1'b1;
            @(negedge clk);
            chk("t2_w_held_low", axi_req.w_valid, 1'b0);
            chk("t2_aw_pending", axi_req.aw_valid, 1'b1);
            tick();
        end
        axi_rsp.aw_ready = 1'b0;
        axi_rsp.b_valid  = 1'b1;
        axi_rsp.b.resp   = AXI_RESP_EXOKAY;
        @(negedge clk);
        chk("t2_bready", axi_req.b_ready, 1'b1);
        chk("t2_aw_dropped", axi_req.aw_valid, 1'b0);
        tick();
        axi_rsp.b_valid = 1'b0;
        wait_rsp(4, cyc);
        tick();
        @(negedge clk);
        chk("t2_rvalid_count", rv_cnt - rv0, 1);
        chk("t2_aw_count", aw_hs_cnt - aw0, 1);
        chk("t2_w_count", w_hs_cnt - w0, 1);
        tick();

        // Read with a five-cycle R latency; a waiting request is never granted
        rv0 = rv_cnt;
        issue(1'b0, 4'hF, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, 1'b0);
        axi_rsp.ar_ready = 1'b1;
        @(negedge clk);
        chk("t3_arvalid", axi_req.ar_valid, 1'b1);
        chk("t3_araddr", axi_req.ar.addr, 32'h1000_0000);
        chk("t3_arid", axi_req.ar.id, TB_ID);
        chk("t3_arlen", axi_req.ar.len, 8'd0);
        chk("t3_arsize", axi_req.ar.size, 3'b010);
        chk("t3_arburst", axi_req.ar.burst, 2'b01);
        chk("t3_rready_req", axi_req.r_ready, 1'b0);
        tick();
        axi_rsp.ar_ready = 1'b0;
        obi_req.req  = 1'b1;
        obi_req.we   = 1'b0;
        obi_req.addr = 32'h1000_0040;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_gnt_low", obi_resp.gnt, 1'b0);
            chk("t3_rready", axi_req.r_ready, 1'b1);
            tick();
        end
        axi_rsp.r_valid = 1'b1;
        axi_rsp.r.data  = 32'hCAFE_F00D;
        axi_rsp.r.resp  = AXI_RESP_OKAY;
        axi_rsp.r.last  = 1'b1;
        tick();
        axi_rsp.r_valid = 1'b0;
        wait_rsp(4, cyc);
        chk("t3_gnt_resp", obi_resp.gnt, 1'b0);
        obi_req.req = 1'b0;
        tick();
        @(negedge clk);
        chk("t3_rvalid_count", rv_cnt - rv0, 1);
        tick();

        // Read answered with DECERR
        issue(1'b0, 4'hF, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1'b1);
        axi_rsp.ar_ready = 1'b1;
        tick();
        axi_rsp.ar_ready = 1'b0;
        axi_rsp.r_valid  = 1'b1;
        axi_rsp.r.data   = 32'h1111_2222;
        axi_rsp.r.resp   = AXI_RESP_DECERR;
        tick();
        axi_rsp.r_valid = 1'b0;
        wait_rsp(4, cyc);
        tick();
        @(negedge clk);
        chk("t4_err_one_cycle", err, 1'b0);
        chk("t4_idle", busy, 1'b0);
        tick();

        // Timeout: R withheld for 40 cycles, then discarded in DRAIN
        rv0 = rv_cnt;
        issue(1'b0, 4'hF, 32'h3000_0000, 32'h0, 32'hDEAD_BEEF, 1'b1);
        axi_rsp.ar_ready = 1'b1;
        wait_rsp(TO_CYCLES + 8, cyc);
        chk("t5_timeout_latency", cyc, TO_CYCLES + 1);
        for (int i = 0; i < 40 - (TO_CYCLES + 1); i++) begin
            tick();
            axi_rsp.ar_ready = 1'b0;
            obi_req.req   = 1'b1;
            obi_req.we    = 1'b1;
            obi_req.be    = 4'hF;
            obi_req.addr  = 32'h2000_0040;
            obi_req.wdata = 32'h1234_5678;
            @(negedge clk);
            chk("t5_drain_busy", busy, 1'b1);
            chk("t5_drain_rready", axi_req.r_ready, 1'b1);
            chk("t5_drain_gnt", obi_resp.gnt, 1'b0);
        end
        tick();
        axi_rsp.r_valid = 1'b1;
        axi_rsp.r.data  = 32'h5555_AAAA;
        axi_rsp.r.resp  = AXI_RESP_OKAY;
        @(negedge clk);
        chk("t5_late_r_busy", busy, 1'b1);
        chk("t5_late_r_gnt", obi_resp.gnt, 1'b0);
        tick();
        axi_rsp.r_valid = 1'b0;

        // Held write is granted right after DRAIN; a read queues behind it
        @(negedge clk);
        chk("t5_no_extra_rvalid", rv_cnt - rv0, 1);
        chk("t6_gnt_after_drain", obi_resp.gnt, 1'b1);
        sb_q.push_back('{rdata: 32'h0, err: 1'b0});
        tick();
        obi_req.we   = 1'b0;
        obi_req.addr = 32'h1000_0100;
        axi_rsp.aw_ready = 1'b1;
        axi_rsp.w_ready  = 1'b1;
        @(negedge clk);
        chk("t6_gnt_wr_req", obi_resp.gnt, 1'b0);
        tick();
        axi_rsp.aw_ready = 1'b0;
        axi_rsp.w_ready  = 1'b0;
        axi_rsp.b_valid  = 1'b1;
        axi_rsp.b.resp   = AXI_RESP_OKAY;
        @(negedge clk);
        chk("t6_gnt_wr_b", obi_resp.gnt, 1'b0);
        tick();
        axi_rsp.b_valid = 1'b0;
        wait_rsp(4, cyc);
        chk("t6_gnt_resp", obi_resp.gnt, 1'b0);
        tick();
        @(negedge clk);
        chk("t6_gnt_second", obi_resp.gnt, 1'b1);
        sb_q.push_back('{rdata: 32'h7777_8888, err: 1'b0});
        tick();
        obi_req.req = 1'b0;
        axi_rsp.ar_ready = 1'b1;
        @(negedge clk);
        chk("t6_araddr", axi_req.ar.addr, 32'h1000_0100);
        tick();
        axi_rsp.ar_ready = 1'b0;
        axi_rsp.r_valid  = 1'b1;
        axi_rsp.r.data   = 32'h7777_8888;
        axi_rsp.r.resp   = AXI_RESP_OKAY;
        tick();
        axi_rsp.r_valid = 1'b0;
        wait_rsp(4, cyc);
        tick();

        // Reset while waiting in WR_B abandons the transfer
        rv0 = rv_cnt;
        issue(1'b1, 4'hF, 32'h2000_0080, 32'hFFFF_0000, 32'h0, 1'b0);
        axi_rsp.aw_ready = 1'b1;
        axi_rsp.w_ready  = 1'b1;
        tick();
        axi_rsp.aw_ready = 1'b0;
        axi_rsp.w_ready  = 1'b0;
        @(negedge clk);
        chk("t7_in_wr_b", axi_req.b_ready, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("t7_busy", busy, 1'b0);
        chk("t7_gnt", obi_resp.gnt, 1'b0);
        chk("t7_rvalid", obi_resp.rvalid, 1'b0);
        chk("t7_rdata", obi_resp.rdata, 32'h0);
        chk("t7_err", err, 1'b0);
        chk("t7_valids", {axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                          axi_req.b_ready, axi_req.r_ready}, 5'b0);
        chk("t7_no_rvalid", rv_cnt - rv0, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
